// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine: writes a solid colour into the framebuffer write port,
// one pixel per clock, optionally deferred to the next vertical blank.
module fb_rect_fill #(
    parameter int unsigned FB_WIDTH    = 320,
    parameter int unsigned FB_HEIGHT   = 240,
    parameter int unsigned ADDR_WIDTH  = 17,
    parameter int unsigned PIXEL_WIDTH = 12
) (
    input  logic                   clock,
    input  logic                   nreset,
    input  logic                   start,
    input  logic [8:0]             x,
    input  logic [7:0]             y,
    input  logic [8:0]             width,
    input  logic [7:0]             height,
    input  logic [PIXEL_WIDTH-1:0] color,
    input  logic                   wait_vblank,
    input  logic                   v_blank_interupt,
    output logic [ADDR_WIDTH-1:0]  fb_addr,
    output logic [PIXEL_WIDTH-1:0] fb_data,
    output logic                   fb_we,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned XW = 9;
    localparam int unsigned YW = 8;
    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned PW = PIXEL_WIDTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_VB = 3'd1,
        SETUP   = 3'd2,
        FILL    = 3'd3,
        FINISH  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d, w_q, w_d, eff_w_q, eff_w_d, col_q, col_d;
    logic [YW-1:0] y_q, y_d, h_q, h_d, eff_h_q, eff_h_d, row_q, row_d;
    logic [PW-1:0] color_q, color_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic          rej_hold_q, rej_hold_d;
    logic [AW-1:0] fb_addr_q, fb_addr_d;
    logic [PW-1:0] fb_data_q, fb_data_d;
    logic          fb_we_q, fb_we_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [XW-1:0] room_w;
    logic [YW-1:0] room_h;
    logic          reject;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            eff_w_q    <= '0;
            eff_h_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            rej_hold_q <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            fb_we_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            color_q    <= color_d;
            eff_w_q    <= eff_w_d;
            eff_h_q    <= eff_h_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            rej_hold_q <= rej_hold_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            fb_we_q    <= fb_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        eff_w_d    = eff_w_q;
        eff_h_d    = eff_h_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        rej_hold_d = rej_hold_q;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        fb_we_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        room_w     = XW'(FB_WIDTH) - x_q;
        room_h     = YW'(FB_HEIGHT) - y_q;
        reject     = (x >= XW'(FB_WIDTH)) || (y >= YW'(FB_HEIGHT)) ||
                     (width == '0) || (height == '0);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    w_d     = width;
                    h_d     = height;
                    color_d = color;
                    if (reject) begin
                        err_d      = 1'b1;
                        rej_hold_d = 1'b1;
                        state_d    = FINISH;
                    end else begin
                        err_d   = 1'b0;
                        state_d = wait_vblank ? WAIT_VB : SETUP;
                    end
                end
            end
            WAIT_VB: begin
                if (!v_blank_interupt) state_d = SETUP;
            end
            SETUP: begin
                // Clip to the framebuffer edge; out-of-range origins were rejected earlier.
                eff_w_d    = (w_q > room_w) ? room_w : w_q;
                eff_h_d    = (h_q > room_h) ? room_h : h_q;
                row_base_d = AW'(y_q) * AW'(FB_WIDTH);
                col_d      = '0;
                row_d      = '0;
                state_d    = FILL;
            end
            FILL: begin
                fb_we_d   = 1'b1;
                fb_addr_d = row_base_q + AW'(x_q) + AW'(col_q);
                fb_data_d = color_q;
                if (col_q == eff_w_q - XW'(1)) begin
                    col_d      = '0;
                    row_d      = row_q + YW'(1);
                    row_base_d = row_base_q + AW'(FB_WIDTH);
                    if (row_q == eff_h_q - YW'(1)) state_d = FINISH;
                end else begin
                    col_d = col_q + XW'(1);
                end
            end
            FINISH: begin
                // A rejected start lingers one extra cycle so done keeps the zero-pixel latency.
                if (rej_hold_q) begin
                    rej_hold_d = 1'b0;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign fb_addr = fb_addr_q;
    assign fb_data = fb_data_q;
    assign fb_we   = fb_we_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill: a cycle-indexed reference model of the
// expected write schedule is compared against the DUT after every rising edge.
module tb_fb_rect_fill;

    localparam int BIG = 1 << 30;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  x = '0;
    logic [7:0]  y = '0;
    logic [8:0]  width = '0;
    logic [7:0]  height = '0;
    logic [11:0] color = '0;
    logic        wait_vblank = 1'b0;
    logic        v_blank_interupt = 1'b1;
    logic [16:0] fb_addr;
    logic [11:0] fb_data;
    logic        fb_we, busy, done, err;

    fb_rect_fill dut (
        .clock(clock), .nreset(nreset), .start(start), .x(x), .y(y),
        .width(width), .height(height), .color(color), .wait_vblank(wait_vblank),
        .v_blank_interupt(v_blank_interupt), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_we(fb_we), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: one outstanding fill described by its cycle schedule.
    bit m_rst = 1'b1;
    bit m_waiting = 1'b0;
    int m_busy_from = BIG, m_done = -1, m_wstart = BIG, m_n = 0;
    int m_x = 0, m_y = 0, m_ew = 1, m_color = 0;
    int m_err_old = 0, m_err_new = 0, m_err_cyc = 0;

    int log_addr[$], log_data[$], log_cyc[$];
    int done_cnt = 0, last_done_cyc = -1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int exp_we(input int c);
        return (!m_rst && c >= m_wstart && c < m_wstart + m_n) ? 1 : 0;
    endfunction

    function automatic int exp_addr(input int c);
        int k = c - m_wstart;
        return (m_y + k / m_ew) * 320 + m_x + k % m_ew;
    endfunction

    function automatic int exp_err(input int c);
        if (m_rst) return 0;
        return (c >= m_err_cyc) ? m_err_new : m_err_old;
    endfunction

    function automatic int exp_busy(input int c);
        return (!m_rst && c >= m_busy_from && (m_waiting || c < m_done)) ? 1 : 0;
    endfunction

    // Compare process: every cycle, shortly after the rising edge.
    always @(posedge clock) begin
        cyc = cyc + 1;
        #1;
        if (m_rst) begin
            chk("rst_we", 32'(fb_we), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_err", 32'(err), 0);
            chk("rst_addr", 32'(fb_addr), 0);
            chk("rst_data", 32'(fb_data), 0);
        end else begin
            chk("we", 32'(fb_we), exp_we(cyc));
            chk("done", 32'(done), (cyc == m_done) ? 1 : 0);
            chk("busy", 32'(busy), exp_busy(cyc));
            chk("err", 32'(err), exp_err(cyc));
            if (exp_we(cyc) == 1) begin
                chk("addr", 32'(fb_addr), exp_addr(cyc));
                chk("data", 32'(fb_data), m_color);
            end
        end
        if (fb_we) begin
            log_addr.push_back(32'(fb_addr));
            log_data.push_back(32'(fb_data));
            log_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        done_cnt = 0;
    endtask

    // Drive a start pulse (at a falling edge) and update the model if the DUT will accept it.
    task automatic do_start(input int xv, input int yv, input int wv, input int hv,
                            input int cv, input bit wb, input bit vb0, output int e);
        int ew, eh;
        x = 9'(xv); y = 8'(yv); width = 9'(wv); height = 8'(hv);
        color = 12'(cv); wait_vblank = wb; start = 1'b1;
        v_blank_interupt = vb0 ? 1'b0 : 1'b1;
        e = cyc + 1;
        if (!m_waiting && e > m_done) begin
            m_err_old = exp_err(cyc);
            m_err_cyc = e;
            m_busy_from = e;
            if (xv >= 320 || yv >= 240 || wv == 0 || hv == 0) begin
                m_err_new = 1;
                m_n = 0;
                m_wstart = BIG;
                m_done = e + 2;
            end else begin
                m_err_new = 0;
                ew = (wv < 320 - xv) ? wv : 320 - xv;
                eh = (hv < 240 - yv) ? hv : 240 - yv;
                m_x = xv; m_y = yv; m_ew = ew; m_n = ew * eh; m_color = cv;
                if (wb) begin
                    m_waiting = 1'b1;
                    m_wstart = BIG;
                    m_done = BIG;
                end else begin
                    m_wstart = e + 2;
                    m_done = e + 2 + m_n;
                end
            end
        end
        @(negedge clock);
        start = 1'b0;
        v_blank_interupt = 1'b1;
        x = 9'($urandom); y = 8'($urandom); width = 9'($urandom);
        height = 8'($urandom); color = 12'($urandom); wait_vblank = 1'($urandom);
    endtask

    task automatic pulse_vb(output int p);
        v_blank_interupt = 1'b0;
        p = cyc + 1;
        if (m_waiting && p > m_busy_from) begin
            m_waiting = 1'b0;
            m_wstart = p + 2;
            m_done = p + 2 + m_n;
        end
        @(negedge clock);
        v_blank_interupt = 1'b1;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((m_waiting || cyc <= m_done) && g < 20000) begin
            @(negedge clock);
            g++;
        end
        if (g >= 20000) chk("timeout_idle", g, 0);
        repeat (2) @(negedge clock);
    endtask

    task automatic do_reset_model();
        m_waiting = 1'b0;
        m_busy_from = BIG; m_done = -1; m_wstart = BIG; m_n = 0;
        m_err_old = 0; m_err_new = 0; m_err_cyc = 0;
    endtask

    initial begin
        int e, p, xv, yv, wv, hv;
        bit wb, vb0;
        int t1_addr[8] = '{0, 1, 2, 3, 320, 321, 322, 323};

        repeat (3) @(negedge clock);
        chk("por_busy", 32'(busy), 0);
        chk("por_we", 32'(fb_we), 0);
        nreset = 1'b1;
        m_rst = 1'b0;
        do_reset_model();
        repeat (2) @(negedge clock);

        // Basic 4x2 fill.
        clear_log();
        do_start(0, 0, 4, 2, 12'hF00, 1'b0, 1'b0, e);
        wait_idle();
        chk("t1_count", log_addr.size(), 8);
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            chk("t1_addr", log_addr[i], t1_addr[i]);
            chk("t1_data", log_data[i], 12'hF00);
        end
        if (log_cyc.size() > 0) chk("t1_first_lat", log_cyc[0] - e, 2);
        chk("t1_done_cyc", last_done_cyc - e, 10);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_err", 32'(err), 0);

        // Clipped at bottom-right corner.
        clear_log();
        do_start(318, 239, 10, 5, 12'h0A5, 1'b0, 1'b0, e);
        wait_idle();
        chk("t2_count", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            chk("t2_addr0", log_addr[0], 76798);
            chk("t2_addr1", log_addr[1], 76799);
        end
        chk("t2_err", 32'(err), 0);

        // Rejected start, then a valid one clears err.
        clear_log();
        do_start(320, 0, 1, 1, 12'h123, 1'b0, 1'b0, e);
        wait_idle();
        chk("t3_writes", log_addr.size(), 0);
        chk("t3_err", 32'(err), 1);
        chk("t3_done_lat", last_done_cyc - e, 2);
        do_start(0, 0, 1, 1, 12'h321, 1'b0, 1'b0, e);
        wait_idle();
        chk("t3_err_clr", 32'(err), 0);

        // Deferred to vblank.
        clear_log();
        do_start(5, 2, 1, 1, 12'h0F0, 1'b1, 1'b0, e);
        repeat (49) @(negedge clock);
        chk("t4_pre_writes", log_addr.size(), 0);
        pulse_vb(p);
        wait_idle();
        chk("t4_count", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            chk("t4_addr", log_addr[0], 645);
            chk("t4_lat_ok", (log_cyc[0] - p <= 3) ? 1 : 0, 1);
        end

        // Reset in the middle of a 16x16 fill.
        clear_log();
        do_start(10, 10, 16, 16, 12'hABC, 1'b0, 1'b0, e);
        repeat (100) @(negedge clock);
        nreset = 1'b0;
        m_rst = 1'b1;
        do_reset_model();
        #1;
        chk("t5_async_we", 32'(fb_we), 0);
        chk("t5_async_busy", 32'(busy), 0);
        chk("t5_async_addr", 32'(fb_addr), 0);
        repeat (3) @(negedge clock);
        nreset = 1'b1;
        m_rst = 1'b0;
        clear_log();
        repeat (300) @(negedge clock);
        chk("t5_post_writes", log_addr.size(), 0);
        chk("t5_post_done", done_cnt, 0);

        // Start during a fill is ignored.
        clear_log();
        do_start(0, 0, 3, 3, 12'h555, 1'b0, 1'b0, e);
        repeat (3) @(negedge clock);
        do_start(100, 100, 5, 5, 12'h777, 1'b0, 1'b0, p);
        wait_idle();
        chk("t6_count", log_addr.size(), 9);
        chk("t6_done_cnt", done_cnt, 1);

        // Randomized fills, including rejects, clipping, vblank deferral and stray starts.
        for (int it = 0; it < 30; it++) begin
            xv = ($urandom_range(0, 9) == 0) ? $urandom_range(320, 511) : $urandom_range(0, 319);
            yv = ($urandom_range(0, 9) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 239);
            if ($urandom_range(0, 9) == 0) wv = 0;
            else wv = (xv > 280) ? $urandom_range(1, 511) : $urandom_range(1, 40);
            if ($urandom_range(0, 9) == 0) hv = 0;
            else hv = (yv > 225) ? $urandom_range(1, 255) : $urandom_range(1, 12);
            wb = 1'($urandom_range(0, 1));
            vb0 = wb && ($urandom_range(0, 3) == 0);
            do_start(xv, yv, wv, hv, 32'($urandom_range(0, 4095)), wb, vb0, e);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 5)) @(negedge clock);
                do_start(32'($urandom_range(0, 319)), 32'($urandom_range(0, 239)),
                         32'($urandom_range(1, 8)), 32'($urandom_range(1, 4)),
                         32'($urandom_range(0, 4095)), 1'b0, 1'b0, p);
            end
            for (int k = 0; k < 10 && m_waiting; k++) begin
                repeat ($urandom_range(1, 15)) @(negedge clock);
                pulse_vb(p);
            end
            if ($urandom_range(0, 2) == 0) pulse_vb(p);
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_rect_fill.md
Name: fb_rect_fill

Overview:
- Hardware rectangle-fill engine that writes a solid colour into the framebuffer through its write port (port A). The VGA scan-out reads the same framebuffer on port B.
- Sits directly upstream of the scan-out path. The CPU programs a rectangle and pulses start; the engine writes one pixel per clock.
- Can defer the start of a fill until the next vertical-blank interrupt, so no partial fill is ever displayed.
- Framebuffer is FB_WIDTH x FB_HEIGHT pixels, row-major, address = y*FB_WIDTH + x.

Parameters:
FB_WIDTH, 320, pixels per framebuffer row
FB_HEIGHT, 240, rows in framebuffer
ADDR_WIDTH, 17, framebuffer address width
PIXEL_WIDTH, 12, pixel colour width (RGB444)

Ports:
clock  in  1  system clock; all state changes on rising edge
nreset  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; ignored unless busy=0
x  in  9  left column of rectangle
y  in  8  top row of rectangle
width  in  9  rectangle width in pixels
height  in  8  rectangle height in rows
color  in  PIXEL_WIDTH  fill colour
wait_vblank  in  1  when 1 at start, writes begin only after the next vblank pulse
v_blank_interupt  in  1  active-low one-cycle frame-done pulse from the scan-out controller
fb_addr  out  ADDR_WIDTH  framebuffer port A address
fb_data  out  PIXEL_WIDTH  framebuffer port A write data
fb_we  out  1  framebuffer port A write enable
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at completion
err  out  1  sticky error flag; cleared by the next accepted start

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE. Reset asserted mid-fill aborts immediately; no further writes occur and no done pulse is issued.
- Input capture: on an accepted start, x, y, width, height, color and wait_vblank are captured into registers. Later input changes have no effect on the fill in progress.
- States: IDLE, WAIT_VB, SETUP, FILL, FINISH.
- IDLE -> start=1:
  - Reject if x>=FB_WIDTH, y>=FB_HEIGHT, width==0 or height==0. On reject: err<=1, go to FINISH, no writes.
  - Otherwise err<=0, then go to WAIT_VB if wait_vblank=1, else SETUP.
- WAIT_VB: hold until v_blank_interupt==0 is sampled, then go to SETUP. A vblank pulse in the same cycle as start does not count; the engine waits for the next one.
- Clipping, computed in SETUP:
  - Effective width = min(width, FB_WIDTH-x).
  - Effective height = min(height, FB_HEIGHT-y).
  - Clipping does not set err.
- SETUP (1 cycle):
  - row_base = y*FB_WIDTH, a constant multiply that may be shift-add.
  - Column and row counters are cleared.
- FILL: one write per cycle.
  - fb_we=1, fb_addr=row_base+x+col, fb_data=color, all registered.
  - col increments each write. At col==eff_w-1: col<=0, row_base<=row_base+FB_WIDTH, row increments.
  - After the write at (eff_w-1, eff_h-1): go to FINISH.
  - There are no idle cycles between rows.
- FINISH (1 cycle): done=1, busy=0 on the next cycle, return to IDLE. fb_we=0 in every state except FILL.
- Latency:
  - Without wait_vblank: start at edge N -> first fb_we=1 at edge N+2.
  - Last write is at N+1+eff_w*eff_h; done is at N+2+eff_w*eff_h.
- Width rules: addresses never exceed FB_WIDTH*FB_HEIGHT-1. Arithmetic is done in ADDR_WIDTH bits with no wrap.
- start while busy=1 is ignored; it is not queued.

Test Plan:
- x=0,y=0,w=4,h=2,color=0xF00,wait_vblank=0 -> exactly 8 writes at addrs 0,1,2,3,320,321,322,323, all data 0xF00; first write 2 cycles after start; done 1 cycle after last write; err=0.
- x=318,y=239,w=10,h=5,color=0x0A5 -> clipped to 2x1: writes only at 76798 and 76799; err=0.
- x=320,y=0,w=1,h=1 -> err=1, no fb_we, done pulses 2 cycles after start; a following valid start clears err.
- wait_vblank=1, w=1,h=1,x=5,y=2: start, then v_blank_interupt low 50 cycles later -> no writes before the pulse; single write at addr 645 within 3 cycles after the pulse.
- Assert nreset in the middle of a 16x16 fill -> outputs go to 0 asynchronously; after release, no writes and no done until a new start.
- Pulse start again during a fill of x=0,y=0,w=3,h=3 -> second start ignored; total 9 writes and a single done.
